adder_result_fifo: RTL and testbench

//   Registered result buffer placed directly downstream of adder_32bit.

---
 rtl/adder_result_fifo.sv | 138 +++++++++++++
 tb/tb_adder_result_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// Registered result buffer for adder_32bit: valid/ready FIFO of {carry, sum} plus a saturating carry-out counter.
// Optional per-entry zero flag and out_zero port when ADDER_RES_ZERO_FLAG_EN is defined.
module adder_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_sum,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_sum,
    output logic                     out_cout,
`ifdef ADDER_RES_ZERO_FLAG_EN
    output logic                     out_zero,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cout_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef ADDER_RES_ZERO_FLAG_EN
    localparam int ENTRY_W = 34;
`else
    localparam int ENTRY_W = 33;
`endif

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [ENTRY_W-1:0] entry_in_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] head_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_nxt_s;
    logic [PTR_W-1:0]   rd_nxt_s;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   lvl_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               push_s;
    logic               pop_s;

`ifdef ADDER_RES_ZERO_FLAG_EN
    assign entry_in_s = {(in_sum == 32'h0000_0000), in_cout, in_sum};
    assign out_zero   = head_r[33];
`else
    assign entry_in_s = {in_cout, in_sum};
`endif

    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = out_valid_r & out_ready;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = head_r[31:0];
    assign out_cout  = head_r[32];
    assign level     = level_r;
    assign cout_cnt  = cnt_r;

    // Next-state for pointers, occupancy, counter and the pre-fetched head entry.
    always_comb begin
        wr_nxt_s   = wr_ptr_r;
        rd_nxt_s   = rd_ptr_r;
        lvl_nxt_s  = level_r;
        cnt_nxt_s  = cnt_r;
        head_nxt_s = '0;
        if (clr) begin
            wr_nxt_s  = '0;
            rd_nxt_s  = '0;
            lvl_nxt_s = '0;
            cnt_nxt_s = '0;
        end else begin
            if (push_s) begin
                wr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   lvl_nxt_s = level_r + LVL_W'(1);
                2'b01:   lvl_nxt_s = level_r - LVL_W'(1);
                default: lvl_nxt_s = level_r;
            endcase
            if (push_s && in_cout && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end
        // Head is registered; a push landing at the new head slot is forwarded from the input.
        if (lvl_nxt_s == LVL_W'(0)) begin
            head_nxt_s = '0;
        end else if (push_s && !clr && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = entry_in_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            cnt_r       <= '0;
            head_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            level_r     <= lvl_nxt_s;
            cnt_r       <= cnt_nxt_s;
            head_r      <= head_nxt_s;
            in_ready_r  <= (lvl_nxt_s != LVL_W'(DEPTH));
            out_valid_r <= (lvl_nxt_s != LVL_W'(0));
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_s && !clr) begin
            mem_r[wr_ptr_r] <= entry_in_s;
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Randomised self-checking bench for adder_result_fifo against a queue-based reference model.
module tb_adder_result_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = 32'h0;
    logic        in_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_zero;
    logic [2:0]  level;
    logic [7:0]  cout_cnt;

    logic        s_valid = 1'b0;
    logic        s_ready_unused;
    logic [31:0] s_sum = 32'h0;
    logic        s_cout = 1'b0;
    logic        s_out_valid;
    logic [31:0] s_out_sum;
    logic        s_out_cout;
    logic        s_out_zero;
    logic [2:0]  s_level;
    logic [1:0]  s_cnt;

    int vecs = 0;
    int fails = 0;

    logic [32:0] model_q[$];
    int          model_cnt = 0;

    always #5 clk = ~clk;

    adder_result_fifo #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
`ifdef ADDER_RES_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .level(level), .cout_cnt(cout_cnt)
    );

    adder_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(s_valid), .in_ready(s_ready_unused), .in_sum(s_sum), .in_cout(s_cout),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_sum(s_out_sum), .out_cout(s_out_cout),
`ifdef ADDER_RES_ZERO_FLAG_EN
        .out_zero(s_out_zero),
`endif
        .level(s_level), .cout_cnt(s_cnt)
    );

`ifndef ADDER_RES_ZERO_FLAG_EN
    assign out_zero   = 1'b0;
    assign s_out_zero = 1'b0;
`endif

    function automatic logic [46:0] dut_view();
        return {in_ready, out_valid, level, out_cout, out_zero, out_sum, cout_cnt};
    endfunction

    function automatic logic [46:0] model_view();
        logic [32:0] head;
        logic        zf;
        head = (model_q.size() > 0) ? model_q[0] : 33'h0;
        zf = 1'b0;
`ifdef ADDER_RES_ZERO_FLAG_EN
        zf = (model_q.size() > 0) && (head[31:0] == 32'h0);
`endif
        return {(model_q.size() < DEPTH), (model_q.size() > 0), 3'(model_q.size()),
                head[32], zf, head[31:0], 8'(model_cnt)};
    endfunction

    task automatic model_clear();
        model_q.delete();
        model_cnt = 0;
    endtask

    // One clock: apply inputs, advance the model on the edge, settle 1 time unit.
    task automatic cyc(input logic v, input logic [31:0] s, input logic c,
                       input logic r, input logic cl);
        bit do_push, do_pop;
        in_valid = v; in_sum = s; in_cout = c; out_ready = r; clr = cl;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        @(posedge clk);
        if (cl) begin
            model_clear();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back({c, s});
                if (c && model_cnt < 255) model_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        model_clear();
        vecs++;
        if (dut_view() !== model_view()) begin
            fails++;
            $display("FAIL reset_held got=%h exp=%h", dut_view(), model_view());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (dut_view() !== model_view() || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got=%h exp=%h", dut_view(), model_view());
        end
    endtask

    task automatic test_carry_zero();
        logic [32:0] add;
        add = 33'h0_FFFF_FFFF + 33'h0_0000_0001;
        cyc(1'b1, add[31:0], add[32], 1'b0, 1'b0);
        vecs++;
        if (dut_view() !== model_view() || out_sum !== 32'h0 || out_cout !== 1'b1 || cout_cnt !== 8'd1) begin
            fails++;
            $display("FAIL carry_zero got=%h exp=%h", dut_view(), model_view());
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        vecs++;
        if (dut_view() !== model_view()) begin
            fails++;
            $display("FAIL carry_zero_drain got=%h exp=%h", dut_view(), model_view());
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 32'(i * 32'h11), 1'b0, 1'b0, 1'b0);
            vecs++;
            if (dut_view() !== model_view()) begin
                fails++;
                $display("FAIL fill_%0d got=%h exp=%h", i, dut_view(), model_view());
            end
        end
        vecs++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full level=%0d in_ready=%b exp level=4 in_ready=0", level, in_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            vecs++;
            if (out_sum !== 32'(i * 32'h11) || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL drain_%0d got=%h exp=%h", i, out_sum, 32'(i * 32'h11));
            end
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        vecs++;
        if (dut_view() !== model_view() || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty got=%h exp=%h", dut_view(), model_view());
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, $urandom, 1'($urandom), 1'b1, 1'b0);
            vecs++;
            if (dut_view() !== model_view() || level !== 3'd2) begin
                fails++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, dut_view(), model_view());
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        int pushed;
        pushed = 0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_sum = $urandom; s_cout = 1'b1;
            @(posedge clk); #1;
            pushed++;
            vecs++;
            if (s_cnt !== 2'((pushed > 3) ? 3 : pushed)) begin
                fails++;
                $display("FAIL sat_%0d got=%0d exp=%0d", i, s_cnt, (pushed > 3) ? 3 : pushed);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        vecs++;
        if (dut_view() !== model_view() || level !== 3'd0 || cout_cnt !== 8'd0) begin
            fails++;
            $display("FAIL clr got=%h exp=%h", dut_view(), model_view());
        end
        cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        vecs++;
        if (dut_view() !== model_view()) begin
            fails++;
            $display("FAIL async_rst got=%h exp=%h", dut_view(), model_view());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
            vecs++;
            if (dut_view() !== model_view()) begin
                fails++;
                $display("FAIL rand_%0d got=%h exp=%h", i, dut_view(), model_view());
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_zero();
        test_fill();
        test_back_to_back();
        test_saturate();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
